mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter.sv | 102 ++++++++++
 tb/tb_mode_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Purpose : up/down modulo counter with optional saturation, sync clear/load and wrap pulse.
// Latency : count/wrapped register one edge after the inputs are sampled; tc is combinational.
// Backpressure: none; enable is a per-edge step request and is never stalled.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - asynchronous active-low reset (count=0, wrapped=0)
//   enable     - step count by one in the direction given by up_down
//   clear      - synchronous clear (highest priority)
//   load       - synchronous load of load_value (clamped to MODULUS-1)
//   load_value - value to load
//   up_down    - 1 = count up, 0 = count down
//   count      - registered count, range 0..MODULUS-1
//   tc         - terminal count for the current direction
//   wrapped    - one-cycle pulse after an edge that wrapped the count
//   ovf        - sticky range-limit flag, present only with MODE_COUNTER_OVF_EN defined
//
// Build option: define MODE_COUNTER_OVF_EN to add the ovf port and its register.
module mode_counter #(
  parameter int                WIDTH    = 8,
  parameter longint unsigned   MODULUS  = 256,
  parameter int                SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
`ifdef MODE_COUNTER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Top of the count range, held at register width so every compare is WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic             at_top;
  logic             at_bot;
  logic             at_limit;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_next;

  assign at_top = (count == MAX_VAL);
  assign at_bot = (count == ZERO);

  // A step sits at a range limit when it would leave the range in its direction.
  assign at_limit = up_down ? at_top : at_bot;

  assign tc = at_limit;

  always_comb begin
    count_next   = count;
    wrapped_next = 1'b0;
    if (clear) begin
      count_next = ZERO;
    end else if (load) begin
      // Out-of-range loads clamp to the top of the range.
      count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
      if (at_limit) begin
        if (SATURATE == 0) begin
          count_next   = up_down ? ZERO : MAX_VAL;
          wrapped_next = 1'b1;
        end
      end else begin
        count_next = up_down ? (count + ONE) : (count - ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= ZERO;
      wrapped <= 1'b0;
    end else begin
      count   <= count_next;
      wrapped <= wrapped_next;
    end
  end

`ifdef MODE_COUNTER_OVF_EN
  // Sticky: set by any real step at a limit (wrap or saturate); load leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (!load && enable && at_limit) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mode_counter.sv
// Purpose : checks mode_counter (WIDTH=4, MODULUS=10) in wrap and saturate builds side by side.
// Latency : outputs compared 1 time unit after each rising edge against an arithmetic model.
// Backpressure: not applicable; stimulus is directed steps followed by random steps.
module tb_mode_counter;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       enable     = 1'b0;
  logic       clear      = 1'b0;
  logic       load       = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       up_down    = 1'b1;

  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, wrapped_w, wrapped_s;
`ifdef MODE_COUNTER_OVF_EN
  logic       ovf_w, ovf_s;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: plain integers in 0..9.
  int m_w = 0, m_s = 0;
  bit mw_wr = 0, ms_wr = 0;
  bit mw_ovf = 0, ms_ovf = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(count_w), .tc(tc_w), .wrapped(wrapped_w)
`ifdef MODE_COUNTER_OVF_EN
    , .ovf(ovf_w)
`endif
  );

  mode_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(count_s), .tc(tc_s), .wrapped(wrapped_s)
`ifdef MODE_COUNTER_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model: modular arithmetic on 0..9.
  task automatic model_one(input bit sat, inout int cnt, inout bit wr, inout bit ovf);
    bit limit;
    if (clear) begin
      cnt = 0; wr = 0; ovf = 0;
    end else if (load) begin
      cnt = (int'(load_value) >= 10) ? 9 : int'(load_value);
      wr  = 0;
    end else if (enable) begin
      limit = up_down ? (cnt == 9) : (cnt == 0);
      if (limit) ovf = 1;
      if (limit && sat) begin
        wr = 0;
      end else begin
        wr  = limit;
        cnt = (cnt + (up_down ? 1 : 9)) % 10;
      end
    end else begin
      wr = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt_w"}, 32'(count_w), 32'(m_w));
    check({tag, "_wrap_w"}, 32'(wrapped_w), 32'(mw_wr));
    check({tag, "_tc_w"}, 32'(tc_w), 32'(up_down ? (m_w == 9) : (m_w == 0)));
    check({tag, "_cnt_s"}, 32'(count_s), 32'(m_s));
    check({tag, "_wrap_s"}, 32'(wrapped_s), 32'(ms_wr));
    check({tag, "_tc_s"}, 32'(tc_s), 32'(up_down ? (m_s == 9) : (m_s == 0)));
`ifdef MODE_COUNTER_OVF_EN
    check({tag, "_ovf_w"}, 32'(ovf_w), 32'(mw_ovf));
    check({tag, "_ovf_s"}, 32'(ovf_s), 32'(ms_ovf));
`endif
  endtask

  task automatic set_in(input bit en, input bit cl, input bit ld, input logic [3:0] lv, input bit ud);
    enable = en; clear = cl; load = ld; load_value = lv; up_down = ud;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_one(1'b0, m_w, mw_wr, mw_ovf);
    model_one(1'b1, m_s, ms_wr, ms_ovf);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_w = 0; m_s = 0; mw_wr = 0; ms_wr = 0; mw_ovf = 0; ms_ovf = 0;
  endtask

  initial begin
    // Reset held from time 0: outputs must already be zero.
    #12;
    check_all("reset");
    reset = 1'b1;

    // Count up 12 steps from 0: 1..9,0,1,2 with a wrap pulse after 9->0.
    set_in(1, 0, 0, 4'd0, 1);
    repeat (12) step("up");

    // Down from 0 for two steps: wrap build 9 then 8, saturate build holds 0.
    set_in(0, 1, 0, 4'd0, 0);
    step("clr");
    set_in(1, 0, 0, 4'd0, 0);
    repeat (2) step("down");
    set_in(0, 0, 0, 4'd0, 0);
    step("hold");

    // Out-of-range load clamps; clear beats load and enable together.
    set_in(0, 0, 1, 4'd13, 1);
    step("load13");
    set_in(1, 1, 1, 4'd5, 1);
    step("cl_ld_en");

    // At the top, step up: saturate holds and flags; load keeps the flag; clear drops it.
    set_in(0, 0, 1, 4'd9, 1);
    step("load9");
    set_in(1, 0, 0, 4'd0, 1);
    step("limit_up");
    set_in(0, 0, 1, 4'd3, 1);
    step("load3");
    set_in(0, 1, 0, 4'd0, 1);
    step("clr_ovf");

    // Reset mid-cycle while counting at 5: immediate zero, restart from 0.
    set_in(0, 0, 1, 4'd4, 1);
    step("load4");
    set_in(1, 0, 0, 4'd0, 1);
    step("to5");
    set_in(1, 0, 1, 4'd7, 1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    #2;
    reset = 1'b1;
    set_in(1, 0, 0, 4'd0, 1);
    step("post_rst");

    // Random traffic: frequent enables and direction changes, occasional load and clear.
    repeat (300) begin
      set_in(($urandom_range(3, 0) != 0),
             ($urandom_range(15, 0) == 0),
             ($urandom_range(7, 0) == 0),
             4'($urandom_range(15, 0)),
             $urandom_range(1, 0) == 1);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
